// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } pll_state_e;

  localparam int RETRY_W = 2;

  localparam int DEF_RESET_HOLD_CYCLES   = 12;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 12000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;
  localparam int DEF_MAX_RETRIES         = 3;

  // Largest of the three cycle parameters; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2_bit.sv
// Two-flop synchronizer for a single asynchronous bit, sync reset to 0.
module sync2_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  // Shift the raw bit through two flops to settle metastability.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock sequencer on the reference clock.
// Hold PLL in reset, wait for lock, require a stable lock window, then
// release the core-domain reset. Timeouts retry up to MAX_RETRIES, then FAULT.
// Build option: PLL_SEQ_LOSS_RECOVERY_EN -- when defined, loss of lock in RUN
// restarts the sequence; otherwise it only sets a sticky lock_lost_q flag.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic               REFERENCECLK,
  input  logic               RESET,
  input  logic               PLL_LOCK,
  input  logic               RELOCK_REQ,
  output logic               PLL_RESETB,
  output logic               CORE_RESET,
  output logic               READY,
  output logic               FAULT,
  output logic [RETRY_W-1:0] RETRY_COUNT
);

  localparam int CNT_MAX = max3(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Counter runs load..0, so each load is the cycle count minus one.
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic lock_s;

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_resetb_q, core_reset_q, ready_q, fault_q;
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
  logic               lock_lost_q, lock_lost_d;
`endif

  sync2_bit u_lock_sync (
    .clk_i (REFERENCECLK),
    .rst_i (RESET),
    .d_i   (PLL_LOCK),
    .q_o   (lock_s)
  );

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
    lock_lost_d = lock_lost_q;
`endif
    if (RELOCK_REQ) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_LD;
      retry_d = '0;
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
      lock_lost_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TOUT_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock wins over a coincident timeout.
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = STABLE_LD;
          end else if (cnt_q == '0) begin
            if (int'(retry_q) < MAX_RETRIES) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_HOLD;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = ST_FAULT;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STABLE: begin
          // Any drop restarts the lock wait with a fresh timeout.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TOUT_LD;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
`ifdef PLL_SEQ_LOSS_RECOVERY_EN
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
            retry_d = '0;
`else
            lock_lost_d = 1'b1;
`endif
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      endcase
    end
  end

  // State register; outputs are decoded from the next state so each one
  // changes on the edge that enters its state.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state_q      <= ST_HOLD;
      cnt_q        <= HOLD_LD;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
      lock_lost_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
      core_reset_q <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
      lock_lost_q  <= lock_lost_d;
`endif
    end
  end

  assign PLL_RESETB  = pll_resetb_q;
  assign CORE_RESET  = core_reset_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized self-checking bench for pll_lock_sequencer.
// Expected release time comes from a timing model: the core is released
// 1 + LOCK_STABLE cycles after the later of (hold end, lock visible
// through the 2-flop synchronizer).
module tb_pll_lock_sequencer;

  localparam int H = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       relock;
  logic       PLL_RESETB;
  logic       CORE_RESET;
  logic       READY;
  logic       FAULT;
  logic [1:0] RETRY_COUNT;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int lock_set_cyc = 0;
  int hold_end_cyc = 0;

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES   (H),
    .LOCK_TIMEOUT_CYCLES (T),
    .LOCK_STABLE_CYCLES  (S),
    .MAX_RETRIES         (R)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst),
    .PLL_LOCK     (lock),
    .RELOCK_REQ   (relock),
    .PLL_RESETB   (PLL_RESETB),
    .CORE_RESET   (CORE_RESET),
    .READY        (READY),
    .FAULT        (FAULT),
    .RETRY_COUNT  (RETRY_COUNT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return PLL_RESETB;
      default: return CORE_RESET;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int which, input logic val, input int limit);
    int n = 0;
    while (sig(which) !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sig(which) !== val) chk({tag, "_timeout"}, 32'(sig(which)), 32'(val));
  endtask

  // One reset edge, check every reset value, then release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    relock = 1'b0;
    step(1);
    chk({tag, "_rst_resetb"}, 32'(PLL_RESETB), 0);
    chk({tag, "_rst_core"},   32'(CORE_RESET), 1);
    chk({tag, "_rst_ready"},  32'(READY), 0);
    chk({tag, "_rst_fault"},  32'(FAULT), 0);
    chk({tag, "_rst_retry"},  32'(RETRY_COUNT), 0);
`ifndef PLL_SEQ_LOSS_RECOVERY_EN
    chk({tag, "_rst_lost"},   32'(dut.lock_lost_q), 0);
`endif
    rst = 1'b0;
    hold_end_cyc = cyc + H;
    lock_set_cyc = cyc;  // synchronizer restarts from 0
  endtask

  task automatic do_relock();
    relock = 1'b1;
    step(1);
    relock = 1'b0;
    hold_end_cyc = cyc + H;
  endtask

  task automatic raise_lock();
    lock = 1'b1;
    lock_set_cyc = cyc;
  endtask

  task automatic check_release(input string tag);
    int exp_rel;
    exp_rel = imax(hold_end_cyc, lock_set_cyc + 2) + 1 + S;
    wait_for(tag, 1, 1'b0, 80);
    chk({tag, "_rel_cyc"}, cyc, exp_rel);
    chk({tag, "_ready"},   32'(READY), 1);
    chk({tag, "_resetb"},  32'(PLL_RESETB), 1);
    chk({tag, "_retry"},   32'(RETRY_COUNT), 0);
  endtask

  initial begin
    int d, g, t0;
    rst = 1'b1;
    lock = 1'b0;
    relock = 1'b0;

    // Reset state and clean lock, PLL_LOCK 3 cycles after PLL_RESETB rises.
    do_reset("init");
    t0 = cyc;
    wait_for("clean_hold", 0, 1'b1, 20);
    chk("clean_hold_len", cyc - t0, H);
    step(3);
    raise_lock();
    check_release("clean");
    chk("clean_delay", cyc - lock_set_cyc, 2 + S + 1);

    // Random lock delays, with and without a one-cycle glitch in STABLE.
    for (int i = 0; i < 8; i++) begin
      lock = 1'b0;
      do_relock();
      wait_for("rnd_hold", 0, 1'b1, 20);
      chk("rnd_hold_end", cyc, hold_end_cyc);
      d = $urandom_range(0, 10);
      step(d);
      raise_lock();
      if (i == 0 || $urandom_range(0, 1) == 1) begin
        g = (i == 0) ? 5 : $urandom_range(1, 6);
        step(2 + g);
        chk("glitch_pre", 32'(CORE_RESET), 1);
        lock = 1'b0;
        step(1);
        raise_lock();
      end
      check_release("rnd");
    end

    // Lock loss while running.
    lock = 1'b0;
`ifdef PLL_SEQ_LOSS_RECOVERY_EN
    step(3);
    chk("loss_core",   32'(CORE_RESET), 1);
    chk("loss_ready",  32'(READY), 0);
    chk("loss_resetb", 32'(PLL_RESETB), 0);
    chk("loss_fault",  32'(FAULT), 0);
    chk("loss_retry",  32'(RETRY_COUNT), 0);
`else
    step(5);
    chk("loss_ready", 32'(READY), 1);
    chk("loss_core",  32'(CORE_RESET), 0);
    chk("loss_lost",  32'(dut.lock_lost_q), 1);
`endif

    // Never locks: R+1 attempts, then FAULT.
    do_reset("nolock");
    t0 = cyc;
    for (int a = 0; a <= R; a++) begin
      wait_for("nl_hold", 0, 1'b1, 20);
      chk("nl_hold_len", cyc - t0, H);
      chk("nl_retry_hold", 32'(RETRY_COUNT), a);
      t0 = cyc;
      wait_for("nl_wait", 0, 1'b0, 40);
      chk("nl_wait_len", cyc - t0, T);
      t0 = cyc;
      if (a < R) begin
        chk("nl_retry", 32'(RETRY_COUNT), a + 1);
        chk("nl_fault_lo", 32'(FAULT), 0);
      end else begin
        chk("nl_fault", 32'(FAULT), 1);
        chk("nl_core", 32'(CORE_RESET), 1);
        chk("nl_retry_sat", 32'(RETRY_COUNT), R);
      end
    end
    step(30);
    chk("nl_fault_sticky", 32'(FAULT), 1);
    chk("nl_resetb_sticky", 32'(PLL_RESETB), 0);
    chk("nl_retry_nowrap", 32'(RETRY_COUNT), R);

    // Recovery from FAULT via RELOCK_REQ with PLL_LOCK high.
    raise_lock();
    step(2);
    do_relock();
    chk("rec_fault",  32'(FAULT), 0);
    chk("rec_retry",  32'(RETRY_COUNT), 0);
    chk("rec_resetb", 32'(PLL_RESETB), 0);
    chk("rec_core",   32'(CORE_RESET), 1);
    check_release("rec");

    // RESET partway through the stable window.
    do_relock();
    step(H + 4);
    chk("stb_core", 32'(CORE_RESET), 1);
    chk("stb_resetb", 32'(PLL_RESETB), 1);
    do_reset("stb");
    check_release("stb_restart");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
